led_pattern_engine: RTL and testbench



---
 rtl/led_pattern_engine.sv | 128 ++++++++++++
 tb/tb_led_pattern_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// N-wide LED pattern sequencer: SCAN, CHASE, ALT and FILL modes stepped by an internal prescaler
// or by manual step pulses while paused. Single clock, synchronous active-high reset.
module led_pattern_engine #(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned TICK_DIV = 3000000,
  parameter int unsigned SPEED_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               step,
  output logic               tick,
  output logic [N_LEDS-1:0]  LED
);

  localparam int unsigned IDX_W = $clog2(N_LEDS + 1);
  localparam logic [IDX_W-1:0] IdxZero = '0;
  localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N_LEDS - 1);
  localparam logic [IDX_W-1:0] IdxFull = IDX_W'(N_LEDS);

  typedef enum logic {DirDown, DirUp} dir_e;

  logic [31:0]       prescaler_q;
  logic [IDX_W-1:0]  idx_q;
  dir_e              dir_q;
  logic              started_q;
  logic [1:0]        mode_q;

  logic [31:0]       period;
  logic [31:0]       limit;
  logic              adv;
  logic [IDX_W-1:0]  nxt_idx;
  dir_e              nxt_dir;
  logic [N_LEDS-1:0] one_hot;
  logic [N_LEDS-1:0] alt_even;
  logic [N_LEDS-1:0] pattern;

  // A speed that shifts the period to zero degrades to stepping every cycle.
  assign period = 32'(TICK_DIV) >> speed;
  assign limit  = (period == 32'd0) ? 32'd0 : period - 32'd1;
  assign adv    = en ? (prescaler_q >= limit) : step;

  always_comb begin
    nxt_idx = idx_q;
    nxt_dir = dir_q;
    // Before the first advance the display shows index 0 without stepping.
    if (started_q) begin
      unique case (mode_q)
        2'd0: begin
          if (dir_q == DirUp) begin
            if (idx_q == IdxLast) begin
              nxt_idx = idx_q - IdxOne;
              nxt_dir = DirDown;
            end else begin
              nxt_idx = idx_q + IdxOne;
            end
          end else begin
            if (idx_q == IdxZero) begin
              nxt_idx = IdxOne;
              nxt_dir = DirUp;
            end else begin
              nxt_idx = idx_q - IdxOne;
            end
          end
        end
        2'd1: nxt_idx = (idx_q == IdxLast) ? IdxZero : idx_q + IdxOne;
        2'd2: nxt_idx = idx_q ^ IdxOne;
        2'd3: nxt_idx = (idx_q == IdxFull) ? IdxZero : idx_q + IdxOne;
        default: nxt_idx = idx_q;
      endcase
    end
  end

  always_comb begin
    one_hot = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      one_hot[i] = (nxt_idx == IDX_W'(i));
    end
    alt_even = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      alt_even[i] = (i % 2 == 0);
    end
    pattern = '0;
    unique case (mode_q)
      2'd0, 2'd1: pattern = one_hot;
      2'd2:       pattern = nxt_idx[0] ? ~alt_even : alt_even;
      2'd3:       pattern = (nxt_idx == IdxFull) ? '1 : one_hot - N_LEDS'(1);
      default:    pattern = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      dir_q       <= DirUp;
      started_q   <= 1'b0;
      mode_q      <= 2'd0;
      tick        <= 1'b0;
      LED         <= '0;
    end else begin
      tick <= 1'b0;
      if (mode != mode_q) begin
        // A mode change swallows any coincident advance; LED holds until the next one.
        mode_q      <= mode;
        idx_q       <= '0;
        dir_q       <= DirUp;
        started_q   <= 1'b0;
        prescaler_q <= '0;
      end else begin
        if (en) begin
          prescaler_q <= (prescaler_q >= limit) ? 32'd0 : prescaler_q + 32'd1;
        end
        if (adv) begin
          tick      <= 1'b1;
          LED       <= pattern;
          idx_q     <= nxt_idx;
          dir_q     <= nxt_dir;
          started_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench: expected LED words are queued with the stimulus and popped by a monitor on
// every tick of an 8-LED and a 4-LED instance.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst, rst4, en, step;
  logic [1:0] mode, mode4, speed;
  logic       tick8, tick4;
  logic [7:0] led8;
  logic [3:0] led4;

  int tests = 0;
  int fails = 0;

  logic [7:0] q8[$];
  logic [3:0] q4[$];
  logic [7:0] e8;
  logic [3:0] e4;

  always #5 clk = ~clk;

  led_pattern_engine #(.N_LEDS(8), .TICK_DIV(8), .SPEED_W(2)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed), .step(step),
    .tick(tick8), .LED(led8)
  );

  led_pattern_engine #(.N_LEDS(4), .TICK_DIV(8), .SPEED_W(2)) dut4 (
    .clk(clk), .rst(rst4), .en(en), .mode(mode4), .speed(speed), .step(step),
    .tick(tick4), .LED(led4)
  );

  // Monitor: every tick must match the oldest queued expectation.
  always @(negedge clk) begin
    if (tick8 === 1'b1) begin
      tests++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL led8_tick: unexpected tick with LED=%h, none expected", led8);
      end else begin
        e8 = q8.pop_front();
        if (led8 !== e8) begin
          fails++;
          $display("FAIL led8_value: LED=%h, required %h", led8, e8);
        end
      end
    end
    if (tick4 === 1'b1) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL led4_tick: unexpected tick with LED=%h, none expected", led4);
      end else begin
        e4 = q4.pop_front();
        if (led4 !== e4) begin
          fails++;
          $display("FAIL led4_value: LED=%h, required %h", led4, e4);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Counts clock edges from the current negedge until the chosen DUT shows tick.
  task automatic gap(input bit sel, input int req, input string name);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < req + 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      hit = sel ? (tick4 === 1'b1) : (tick8 === 1'b1);
    end
    tests++;
    if (!hit || n != req) begin
      fails++;
      $display("FAIL %s: tick after %0d cycles (seen=%0b), required %0d", name, n, hit, req);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [7:0] scan_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    rst = 1'b1; rst4 = 1'b1; en = 1'b1; step = 1'b0;
    mode = 2'd0; mode4 = 2'd0; speed = 2'd0;
    edges(3);
    check("reset_led8", 32'(led8), 32'h0);
    check("reset_tick8", 32'(tick8), 32'h0);
    check("reset_led4", 32'(led4), 32'h0);

    // SCAN at speed 0: first tick 8 cycles after release, then every 8.
    for (int i = 0; i < 16; i++) q8.push_back(scan_seq[i]);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) gap(1'b0, 8, "scan_gap");

    // Speed 0 -> 2 with prescaler at 5: limit drops to 1.
    q8.push_back(8'h04); q8.push_back(8'h08); q8.push_back(8'h10);
    edges(5);
    speed = 2'd2;
    gap(1'b0, 1, "speed_change_gap");
    gap(1'b0, 2, "speed2_gap");
    gap(1'b0, 2, "speed2_gap");

    // Paused: frozen, then three manual steps.
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick8 === 1'b1) cnt++;
    end
    check("pause_ticks", 32'(cnt), 32'd0);
    check("pause_led", 32'(led8), 32'h10);
    q8.push_back(8'h20); q8.push_back(8'h40); q8.push_back(8'h80);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      gap(1'b0, 1, "step_gap");
      step = 1'b0;
      edges(3);
    end

    // Step held high while running must not add advances.
    q8.push_back(8'h40); q8.push_back(8'h20);
    speed = 2'd0; en = 1'b1; step = 1'b1;
    gap(1'b0, 8, "step_ignored_gap");
    step = 1'b0;
    gap(1'b0, 8, "scan_idx5_gap");

    // SCAN -> CHASE at idx 5 going down.
    q8.push_back(8'h01); q8.push_back(8'h02);
    mode = 2'd1;
    @(posedge clk);
    @(negedge clk);
    check("mode_hold_led", 32'(led8), 32'h20);
    check("mode_hold_tick", 32'(tick8), 32'h0);
    gap(1'b0, 8, "chase_first_gap");
    gap(1'b0, 8, "chase_gap");

    // CHASE -> FILL coincident with an advance: no advance that cycle.
    q8.push_back(8'h00); q8.push_back(8'h01); q8.push_back(8'h03);
    edges(7);
    mode = 2'd3;
    gap(1'b0, 9, "coincident_mode_gap");
    gap(1'b0, 8, "fill8_gap");
    gap(1'b0, 8, "fill8_gap");

    q8.push_back(8'h55); q8.push_back(8'hAA); q8.push_back(8'h55);
    mode = 2'd2;
    gap(1'b0, 9, "alt_first_gap");
    gap(1'b0, 8, "alt_gap");
    gap(1'b0, 8, "alt_gap");

    // Reset coincident with an advance.
    edges(7);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_led", 32'(led8), 32'h0);
    check("midrun_reset_tick", 32'(tick8), 32'h0);
    q8.push_back(8'h55);
    rst = 1'b0;
    gap(1'b0, 9, "post_reset_gap");

    // 4-LED instance: CHASE then FILL.
    rst = 1'b1;
    mode4 = 2'd1;
    q4.push_back(4'h1); q4.push_back(4'h2); q4.push_back(4'h4);
    q4.push_back(4'h8); q4.push_back(4'h1);
    rst4 = 1'b0;
    gap(1'b1, 9, "chase4_first_gap");
    for (int i = 0; i < 4; i++) gap(1'b1, 8, "chase4_gap");
    q4.push_back(4'h0); q4.push_back(4'h1); q4.push_back(4'h3);
    q4.push_back(4'h7); q4.push_back(4'hF); q4.push_back(4'h0);
    mode4 = 2'd3;
    gap(1'b1, 9, "fill4_first_gap");
    for (int i = 0; i < 5; i++) gap(1'b1, 8, "fill4_gap");

    edges(2);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
